// File: rtl/game_master_multi_shot.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : game_master_multi_shot                                        |
// | Purpose  : Round controller for a shooting game with several torpedo     |
// |            sprites in flight at once. Each round starts by reloading all |
// |            sprites, then lets the player launch up to SHOTS_PER_ROUND    |
// |            torpedoes (lowest free slot first). The round ends on a hit   |
// |            (win), on the target leaving the screen (loss), or when all   |
// |            shots are spent and every torpedo has left (loss). The end-of-|
// |            round pause is held while the external timer runs.           |
// | Ports    : clk, reset (async, active-high)                                |
// |            key                           fire button level (synchronised)|
// |            sprite_target_within_screen   target visible                  |
// |            sprite_torpedo_within_screen  per-torpedo visible             |
// |            collision                     per-torpedo hit on target       |
// |            end_of_game_timer_running     end-of-round pause active       |
// |            sprite_target_write_xy/_dxy/_enable_update   target controls  |
// |            sprite_torpedo_write_xy/_dxy/_enable_update  torpedo controls |
// |            end_of_game_timer_start       one pulse per round             |
// |            game_won, score, shots_left   round status                    |
// |            All outputs are registered.                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module game_master_multi_shot #(
  parameter int N_TORPEDOES     = 4,
  parameter int SHOTS_PER_ROUND = 6,
  parameter int SCORE_W         = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key,
  input  logic                   sprite_target_within_screen,
  input  logic [N_TORPEDOES-1:0] sprite_torpedo_within_screen,
  input  logic [N_TORPEDOES-1:0] collision,
  input  logic                   end_of_game_timer_running,
  output logic                   sprite_target_write_xy,
  output logic                   sprite_target_write_dxy,
  output logic                   sprite_target_enable_update,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_write_xy,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_write_dxy,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_enable_update,
  output logic                   end_of_game_timer_start,
  output logic                   game_won,
  output logic [SCORE_W-1:0]     score,
  output logic [3:0]             shots_left
);

  typedef enum logic [3:0] {
    S_START = 4'b0001,
    S_PLAY  = 4'b0010,
    S_DRAIN = 4'b0100,
    S_END   = 4'b1000
  } state_t;

  state_t                 state_q, state_d;
  logic                   key_prev_q;
  logic [N_TORPEDOES-1:0] active_q, active_d;
  logic [3:0]             shots_q, shots_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic                   won_q, won_d;
  logic                   tgt_xy_q, tgt_xy_d;
  logic                   tgt_dxy_q, tgt_dxy_d;
  logic                   tgt_en_q, tgt_en_d;
  logic [N_TORPEDOES-1:0] tor_xy_q, tor_xy_d;
  logic [N_TORPEDOES-1:0] tor_dxy_q, tor_dxy_d;
  logic                   timer_start_q, timer_start_d;

  logic                   fire;
  logic                   hit;
  logic [N_TORPEDOES-1:0] exit_mask;
  logic [N_TORPEDOES-1:0] idle_mask;
  logic [N_TORPEDOES-1:0] launch_oh;
  logic                   can_launch;

  // Only torpedoes in flight can hit or leave; idle slots are parked
  // off-screen so their sprite flags are meaningless.
  assign fire       = key & ~key_prev_q;
  assign hit        = |(collision & active_q);
  assign exit_mask  = active_q & ~sprite_torpedo_within_screen;
  assign idle_mask  = ~active_q;
  // Isolate the lowest set bit: the lowest-index idle slot. It is taken from
  // the registered mask, so a slot freed this very cycle is not yet eligible.
  assign launch_oh  = idle_mask & (~idle_mask + N_TORPEDOES'(1));
  assign can_launch = fire && (shots_q != 4'd0) && (|idle_mask);

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    shots_d       = shots_q;
    score_d       = score_q;
    won_d         = won_q;
    tgt_xy_d      = 1'b0;
    tgt_dxy_d     = 1'b0;
    tor_xy_d      = '0;
    tor_dxy_d     = '0;
    timer_start_d = 1'b0;

    case (state_q)
      S_START: begin
        tgt_xy_d  = 1'b1;
        tgt_dxy_d = 1'b1;
        tor_xy_d  = '1;
        shots_d   = 4'(SHOTS_PER_ROUND);
        active_d  = '0;
        won_d     = 1'b0;
        state_d   = S_PLAY;
      end

      S_PLAY, S_DRAIN: begin
        // Torpedoes that left the screen are reloaded and freed.
        tor_xy_d = exit_mask;
        active_d = active_q & ~exit_mask;

        if (hit) begin
          // A hit wins even if the target leaves on the same cycle.
          won_d         = 1'b1;
          timer_start_d = 1'b1;
          if (score_q != {SCORE_W{1'b1}}) begin
            score_d = score_q + SCORE_W'(1);
          end
          active_d      = '0;
          state_d       = S_END;
        end else if (!sprite_target_within_screen) begin
          won_d         = 1'b0;
          timer_start_d = 1'b1;
          active_d      = '0;
          state_d       = S_END;
        end else if (state_q == S_PLAY) begin
          if (can_launch) begin
            tor_dxy_d = launch_oh;
            active_d  = active_d | launch_oh;
            shots_d   = shots_q - 4'd1;
          end
          if (shots_q == 4'd0) begin
            state_d = S_DRAIN;
          end
        end else if (active_q == '0) begin
          // Out of shots and nothing left in flight: the round is lost.
          won_d         = 1'b0;
          timer_start_d = 1'b1;
          state_d       = S_END;
        end
      end

      S_END: begin
        if (!end_of_game_timer_running) begin
          state_d = S_START;
        end
      end

      default: begin
        state_d = S_START;
      end
    endcase

    tgt_en_d = (state_d == S_PLAY) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_START;
      key_prev_q    <= 1'b1;
      active_q      <= '0;
      shots_q       <= 4'd0;
      score_q       <= '0;
      won_q         <= 1'b0;
      tgt_xy_q      <= 1'b0;
      tgt_dxy_q     <= 1'b0;
      tgt_en_q      <= 1'b0;
      tor_xy_q      <= '0;
      tor_dxy_q     <= '0;
      timer_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_prev_q    <= key;
      active_q      <= active_d;
      shots_q       <= shots_d;
      score_q       <= score_d;
      won_q         <= won_d;
      tgt_xy_q      <= tgt_xy_d;
      tgt_dxy_q     <= tgt_dxy_d;
      tgt_en_q      <= tgt_en_d;
      tor_xy_q      <= tor_xy_d;
      tor_dxy_q     <= tor_dxy_d;
      timer_start_q <= timer_start_d;
    end
  end

  assign sprite_target_write_xy       = tgt_xy_q;
  assign sprite_target_write_dxy      = tgt_dxy_q;
  assign sprite_target_enable_update  = tgt_en_q;
  assign sprite_torpedo_write_xy      = tor_xy_q;
  assign sprite_torpedo_write_dxy     = tor_dxy_q;
  // The active mask is cleared on entry to the end-of-round pause, so it
  // doubles as the torpedo movement enable.
  assign sprite_torpedo_enable_update = active_q;
  assign end_of_game_timer_start      = timer_start_q;
  assign game_won                     = won_q;
  assign score                        = score_q;
  assign shots_left                   = shots_q;

endmodule
`default_nettype wire

// File: tb/tb_game_master_multi_shot.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_game_master_multi_shot                                     |
// | Purpose  : Self-checking bench: directed scenarios plus random stimulus  |
// |            compared every cycle against a round-level behavioural model. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_game_master_multi_shot;

  localparam int N   = 4;
  localparam int SPR = 6;
  localparam int SW  = 8;
  localparam int SCORE_MAX = (1 << SW) - 1;

  localparam int P_START = 0;
  localparam int P_PLAY  = 1;
  localparam int P_DRAIN = 2;
  localparam int P_END   = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         key;
  logic         tws;
  logic [N-1:0] torws;
  logic [N-1:0] coll;
  logic         timer_run;

  logic         o_txy, o_tdxy, o_ten, o_ts, o_won;
  logic [N-1:0] o_oxy, o_odxy, o_oen;
  logic [SW-1:0] o_score;
  logic [3:0]   o_shots;

  int errors = 0;
  int checks = 0;

  game_master_multi_shot #(
    .N_TORPEDOES    (N),
    .SHOTS_PER_ROUND(SPR),
    .SCORE_W        (SW)
  ) dut (
    .clk                         (clk),
    .reset                       (reset),
    .key                         (key),
    .sprite_target_within_screen (tws),
    .sprite_torpedo_within_screen(torws),
    .collision                   (coll),
    .end_of_game_timer_running   (timer_run),
    .sprite_target_write_xy      (o_txy),
    .sprite_target_write_dxy     (o_tdxy),
    .sprite_target_enable_update (o_ten),
    .sprite_torpedo_write_xy     (o_oxy),
    .sprite_torpedo_write_dxy    (o_odxy),
    .sprite_torpedo_enable_update(o_oen),
    .end_of_game_timer_start     (o_ts),
    .game_won                    (o_won),
    .score                       (o_score),
    .shots_left                  (o_shots)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int           m_phase, n_phase;
  bit [N-1:0]   m_act, n_act;
  int           m_shots, n_shots, m_score, n_score;
  bit           m_won, n_won, m_keyprev;
  bit           n_txy, n_tdxy, n_ts;
  bit [N-1:0]   n_oxy, n_odxy;
  bit           mf_fire, mf_hit, mf_found;

  bit           e_txy, e_tdxy, e_ten, e_ts, e_won;
  bit [N-1:0]   e_oxy, e_odxy, e_oen;
  int           e_score, e_shots;

  always_comb begin
    n_phase  = m_phase;
    n_act    = m_act;
    n_shots  = m_shots;
    n_score  = m_score;
    n_won    = m_won;
    n_txy    = 1'b0;
    n_tdxy   = 1'b0;
    n_ts     = 1'b0;
    n_oxy    = '0;
    n_odxy   = '0;
    mf_fire  = (key === 1'b1) && !m_keyprev;
    mf_hit   = 1'b0;
    mf_found = 1'b0;
    if (m_phase == P_START) begin
      n_txy   = 1'b1;
      n_tdxy  = 1'b1;
      n_oxy   = '1;
      n_shots = SPR;
      n_act   = '0;
      n_won   = 1'b0;
      n_phase = P_PLAY;
    end else if (m_phase == P_PLAY || m_phase == P_DRAIN) begin
      for (int i = 0; i < N; i++) begin
        if (m_act[i] && coll[i]) mf_hit = 1'b1;
        if (m_act[i] && !torws[i]) begin
          n_oxy[i] = 1'b1;
          n_act[i] = 1'b0;
        end
      end
      if (mf_hit) begin
        n_won   = 1'b1;
        n_ts    = 1'b1;
        n_score = (m_score < SCORE_MAX) ? m_score + 1 : m_score;
        n_act   = '0;
        n_phase = P_END;
      end else if (!tws) begin
        n_won   = 1'b0;
        n_ts    = 1'b1;
        n_act   = '0;
        n_phase = P_END;
      end else if (m_phase == P_PLAY) begin
        if (mf_fire && m_shots > 0) begin
          for (int i = 0; i < N; i++) begin
            if (!mf_found && !m_act[i]) begin
              mf_found  = 1'b1;
              n_odxy[i] = 1'b1;
              n_act[i]  = 1'b1;
            end
          end
          if (mf_found) n_shots = m_shots - 1;
        end
        if (m_shots == 0) n_phase = P_DRAIN;
      end else if (m_act == '0) begin
        n_won   = 1'b0;
        n_ts    = 1'b1;
        n_phase = P_END;
      end
    end else begin
      if (!timer_run) n_phase = P_START;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase   <= P_START;
      m_act     <= '0;
      m_shots   <= 0;
      m_score   <= 0;
      m_won     <= 1'b0;
      m_keyprev <= 1'b1;
      e_txy     <= 1'b0;
      e_tdxy    <= 1'b0;
      e_ten     <= 1'b0;
      e_ts      <= 1'b0;
      e_won     <= 1'b0;
      e_oxy     <= '0;
      e_odxy    <= '0;
      e_oen     <= '0;
      e_score   <= 0;
      e_shots   <= 0;
    end else begin
      m_phase   <= n_phase;
      m_act     <= n_act;
      m_shots   <= n_shots;
      m_score   <= n_score;
      m_won     <= n_won;
      m_keyprev <= key;
      e_txy     <= n_txy;
      e_tdxy    <= n_tdxy;
      e_ten     <= (n_phase == P_PLAY) || (n_phase == P_DRAIN);
      e_ts      <= n_ts;
      e_won     <= n_won;
      e_oxy     <= n_oxy;
      e_odxy    <= n_odxy;
      e_oen     <= n_act;
      e_score   <= n_score;
      e_shots   <= n_shots;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison, well away from the rising edge.
  always @(negedge clk) begin
    check("pulses", 64'({o_txy, o_tdxy, o_oxy, o_odxy, o_ts}),
                    64'({e_txy, e_tdxy, e_oxy, e_odxy, e_ts}));
    check("enables", 64'({o_ten, o_oen}), 64'({e_ten, e_oen}));
    check("game_won", 64'(o_won), 64'(e_won));
    check("score", 64'(o_score), 64'(e_score));
    check("shots_left", 64'(o_shots), 64'(e_shots));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic fire_once();
    key = 1'b1;
    cyc(1);
    key = 1'b0;
    cyc(1);
  endtask

  int tr_cnt = 0;

  initial begin
    reset     = 1'b1;
    key       = 1'b0;
    tws       = 1'b1;
    torws     = '1;
    coll      = '0;
    timer_run = 1'b0;
    cyc(3);
    check("lit_reset_shots", 64'(o_shots), 64'd0);
    check("lit_reset_enables", 64'({o_ten, o_oen}), 64'd0);
    reset = 1'b0;
    cyc(1);
    check("lit_start_pulses", 64'({o_txy, o_tdxy, o_oxy}), 64'h3F);
    check("lit_start_shots", 64'(o_shots), 64'd6);
    cyc(1);
    check("lit_play_target_en", 64'(o_ten), 64'd1);

    // Single fire then target exit.
    key = 1'b1;
    cyc(1);
    check("lit_launch_dxy", 64'(o_odxy), 64'h1);
    check("lit_launch_shots", 64'(o_shots), 64'd5);
    check("lit_launch_en", 64'(o_oen), 64'h1);
    key = 1'b0;
    tws = 1'b0;
    cyc(1);
    check("lit_loss_timer", 64'({o_ts, o_won, o_score}), 64'h200);
    tws = 1'b1;
    timer_run = 1'b1;
    cyc(3);
    timer_run = 1'b0;
    cyc(3);

    // Hit by the second torpedo.
    fire_once();
    fire_once();
    coll = 4'b0010;
    cyc(1);
    check("lit_hit_score", 64'({o_ts, o_won, o_score}), 64'h301);
    coll = '0;
    timer_run = 1'b1;
    cyc(20);
    timer_run = 1'b0;
    cyc(3);
    check("lit_new_round_shots", 64'(o_shots), 64'd6);

    // Slot exhaustion, then reuse of a freed slot.
    repeat (5) fire_once();
    torws = 4'b1011;
    cyc(1);
    torws = '1;
    fire_once();
    // Last shot, then drain with the key held.
    fire_once();
    key = 1'b1;
    cyc(3);
    torws = '0;
    cyc(1);
    torws = '1;
    cyc(3);
    key = 1'b0;
    cyc(4);

    // Collision coincident with target exit.
    fire_once();
    coll = 4'b0001;
    tws  = 1'b0;
    cyc(1);
    coll = '0;
    tws  = 1'b1;
    cyc(1);

    // Many quick wins to reach score saturation.
    for (int r = 0; r < 260; r++) begin
      cyc(2);
      fire_once();
      coll = 4'b0001;
      cyc(1);
      coll = '0;
      cyc(1);
    end
    check("lit_score_saturated", 64'(o_score), 64'd255);

    // Random play.
    for (int c = 0; c < 4000; c++) begin
      key   = ($urandom_range(0, 2) == 0);
      tws   = ($urandom_range(0, 39) != 0);
      for (int i = 0; i < N; i++) begin
        torws[i] = ($urandom_range(0, 11) != 0);
        coll[i]  = ($urandom_range(0, 59) == 0);
      end
      if (tr_cnt > 0) begin
        timer_run = 1'b1;
        tr_cnt--;
      end else begin
        timer_run = 1'b0;
        if ($urandom_range(0, 9) == 0) tr_cnt = $urandom_range(1, 8);
      end
      reset = ($urandom_range(0, 799) == 0);
      cyc(1);
    end
    reset     = 1'b0;
    key       = 1'b0;
    tws       = 1'b1;
    torws     = '1;
    coll      = '0;
    timer_run = 1'b0;
    cyc(4);

    // Asynchronous reset in the middle of a round with three in flight.
    fire_once();
    fire_once();
    fire_once();
    key   = 1'b1;
    reset = 1'b1;
    #1;
    check("lit_async_reset", 64'({o_txy, o_tdxy, o_ten, o_oxy, o_odxy, o_oen,
                                  o_ts, o_won, o_score, o_shots}), 64'd0);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    check("lit_post_reset_start", 64'({o_txy, o_shots, o_score}), 64'h1600);
    cyc(3);
    key = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
